// File: rtl/dmem_fill_ctrl_if.sv
// Cache-side request/response and DMem-side bus bundle for the fill controller.
// Pure wiring; it adds no latency.
// Backpressure is carried by req_valid/req_ready and resp_valid/resp_ready.
interface dmem_fill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wb;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_wb_addr;
    logic [DATA_WIDTH-1:0] req_wb_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The controller side.
    modport slave (
        input  req_valid, req_wb, req_addr, req_wb_addr, req_wb_data,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output mem_addr, mem_data, mem_wr_en
    );

    // The cache + memory side.
    modport master (
        output req_valid, req_wb, req_addr, req_wb_addr, req_wb_data,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  mem_addr, mem_data, mem_wr_en
    );
endinterface

// File: rtl/dmem_fill_ctrl.sv
// Sequences an optional victim writeback then a line fill against single-port DMem.
// Latency after the accept edge: 2 edges (fill), 3 (writeback + fill), error response right at accept.
// One request in flight; response holds stable until resp_ready, req_ready only in IDLE.
module dmem_fill_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE       = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_fill_ctrl_if.slave      bus,
    output logic [CNT_WIDTH-1:0] fill_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WB      = 3'd1;
    localparam logic [2:0] RD      = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] SIZE_L  = ADDR_WIDTH'(SIZE);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  err;

    // Any out-of-range index rejects the whole request before memory is touched.
    assign err = (bus.req_addr >= SIZE_L) || (bus.req_wb && (bus.req_wb_addr >= SIZE_L));

    assign bus.req_ready = (state == IDLE);

    // Request sequencing, memory drive, response capture and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            fill_addr      <= '0;
            bus.mem_addr   <= '0;
            bus.mem_data   <= '0;
            bus.mem_wr_en  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
            fill_cnt       <= '0;
            wb_cnt         <= '0;
        end else begin
            // Write enable is a single-cycle pulse, only ever raised on entry to WB.
            bus.mem_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        fill_addr <= bus.req_addr;
                        if (err) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_data  <= '0;
                        end else if (bus.req_wb) begin
                            state         <= WB;
                            bus.mem_addr  <= bus.req_wb_addr;
                            bus.mem_data  <= bus.req_wb_data;
                            bus.mem_wr_en <= 1'b1;
                        end else begin
                            state        <= RD;
                            bus.mem_addr <= bus.req_addr;
                        end
                    end
                end
                WB: begin
                    // The write lands at this edge, so a same-index read sees new data.
                    state        <= RD;
                    bus.mem_addr <= fill_addr;
                    bus.mem_data <= '0;
                    if (wb_cnt != CNT_MAX) begin
                        wb_cnt <= wb_cnt + 1'b1;
                    end
                end
                RD: begin
                    // DMem registers mem_addr here; data is valid during RD_WAIT.
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    state          <= RESP;
                    bus.resp_data  <= bus.mem_rdata;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    if (fill_cnt != CNT_MAX) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Data and error flag persist after the handshake until the next response.
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_fill_ctrl.sv
// Directed vector bench for dmem_fill_ctrl with a behavioural DMem model.
module tb_dmem_fill_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] fill_cnt;
    logic [15:0] wb_cnt;

    int vecs  = 0;
    int fails = 0;

    dmem_fill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(256)) bus ();

    dmem_fill_ctrl #(
        .DATA_WIDTH(256), .ADDR_WIDTH(32), .SIZE(4096), .CNT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .fill_cnt (fill_cnt),
        .wb_cnt   (wb_cnt)
    );

    always #5 clk = ~clk;

    // DMem model: registered read address, write on wr_en.
    logic [255:0] dmem [0:4095];
    logic [11:0]  raddr = '0;
    always @(posedge clk) begin
        if (bus.mem_wr_en) dmem[bus.mem_addr[11:0]] <= bus.mem_data;
        raddr <= bus.mem_addr[11:0];
    end
    assign bus.mem_rdata = dmem[raddr];

    typedef struct {
        logic         wb;
        logic [31:0]  addr;
        logic [31:0]  wb_addr;
        logic [255:0] wb_data;
        logic         exp_err;
        logic [255:0] exp_data;
        int           exp_lat;
        logic         exp_wr;
        logic [15:0]  exp_fill;
        logic [15:0]  exp_wb;
    } vec_t;

    vec_t vt [10];
    vec_t post_rst;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic wb, input logic [31:0] addr,
                             input logic [31:0] wb_addr, input logic [255:0] wb_data);
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_wb      = wb;
        bus.req_addr    = addr;
        bus.req_wb_addr = wb_addr;
        bus.req_wb_data = wb_data;
        @(posedge clk);
        #1;
        // Scramble fields after accept; the controller must use its latched copy.
        bus.req_valid   = 1'b0;
        bus.req_wb      = ~wb;
        bus.req_addr    = addr ^ 32'd1;
        bus.req_wb_addr = wb_addr ^ 32'd2;
        bus.req_wb_data = ~wb_data;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        int writes;
        logic [31:0]  waddr;
        logic [255:0] wdata;
        bit got;
        lat = 0; writes = 0; waddr = '0; wdata = '0; got = 0;
        bus.resp_ready = 1'b1;
        drive_req(v.wb, v.addr, v.wb_addr, v.wb_data);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en) begin
                writes++;
                waddr = bus.mem_addr;
                wdata = bus.mem_data;
            end
            if (bus.resp_valid) begin
                got = 1;
                break;
            end
            lat++;
        end
        check({tag, "_resp_seen"}, 256'(got), 256'(1));
        check({tag, "_latency"},   256'(lat), 256'(v.exp_lat));
        check({tag, "_resp_err"},  256'(bus.resp_err), 256'(v.exp_err));
        check({tag, "_resp_data"}, bus.resp_data, v.exp_data);
        check({tag, "_req_ready_busy"}, 256'(bus.req_ready), 256'(0));
        check({tag, "_wr_pulses"}, 256'(writes), 256'(v.exp_wr ? 1 : 0));
        if (v.exp_wr) begin
            check({tag, "_wr_addr"}, 256'(waddr), 256'(v.wb_addr));
            check({tag, "_wr_data"}, wdata, v.wb_data);
        end
        check({tag, "_fill_cnt"}, 256'(fill_cnt), 256'(v.exp_fill));
        check({tag, "_wb_cnt"},   256'(wb_cnt),   256'(v.exp_wb));
        @(negedge clk);
        check({tag, "_resp_valid_drop"}, 256'(bus.resp_valid), 256'(0));
        check({tag, "_req_ready_idle"},  256'(bus.req_ready),  256'(1));
        check({tag, "_resp_data_hold"},  bus.resp_data, v.exp_data);
    endtask

    initial begin
        //           wb  addr           wb_addr        wb_data        err  exp_data          lat wr  fill wb
        vt[0] = '{1'b0, 32'd5,         32'd0,         256'h0,        1'b0, 256'hA5,         2, 1'b0, 16'd1, 16'd0};
        vt[1] = '{1'b1, 32'd5,         32'd9,         256'h1234,     1'b0, 256'hA5,         3, 1'b1, 16'd2, 16'd1};
        vt[2] = '{1'b1, 32'd7,         32'd7,         256'hBEEF,     1'b0, 256'hBEEF,       3, 1'b1, 16'd3, 16'd2};
        vt[3] = '{1'b0, 32'd4095,      32'd0,         256'h0,        1'b0, 256'hFFF00001,   2, 1'b0, 16'd4, 16'd2};
        vt[4] = '{1'b0, 32'd4096,      32'd0,         256'h0,        1'b1, 256'h0,          0, 1'b0, 16'd4, 16'd2};
        vt[5] = '{1'b1, 32'd3,         32'd4096,      256'hDEAD,     1'b1, 256'h0,          0, 1'b0, 16'd4, 16'd2};
        vt[6] = '{1'b1, 32'd4096,      32'd0,         256'hDEAD,     1'b1, 256'h0,          0, 1'b0, 16'd4, 16'd2};
        vt[7] = '{1'b0, 32'd9,         32'd0,         256'h0,        1'b0, 256'h1234,       2, 1'b0, 16'd5, 16'd2};
        vt[8] = '{1'b0, 32'd0,         32'd0,         256'h0,        1'b0, 256'h77,         2, 1'b0, 16'd6, 16'd2};
        vt[9] = '{1'b1, 32'hFFFF_FFFF, 32'd4095,      256'h55,       1'b1, 256'h0,          0, 1'b0, 16'd6, 16'd2};
        post_rst = '{1'b0, 32'd5,      32'd0,         256'h0,        1'b0, 256'hA5,         2, 1'b0, 16'd1, 16'd0};

        for (int i = 0; i < 4096; i++) dmem[i] = '0;
        dmem[0]    = 256'h77;
        dmem[5]    = 256'hA5;
        dmem[4095] = 256'hFFF00001;

        bus.req_valid   = 1'b0;
        bus.req_wb      = 1'b0;
        bus.req_addr    = '0;
        bus.req_wb_addr = '0;
        bus.req_wb_data = '0;
        bus.resp_ready  = 1'b1;

        // Reset state while reset is held low.
        #12;
        check("rst_req_ready",  256'(bus.req_ready),  256'(1));
        check("rst_resp_valid", 256'(bus.resp_valid), 256'(0));
        check("rst_resp_err",   256'(bus.resp_err),   256'(0));
        check("rst_resp_data",  bus.resp_data,        256'h0);
        check("rst_mem_addr",   256'(bus.mem_addr),   256'(0));
        check("rst_mem_wr_en",  256'(bus.mem_wr_en),  256'(0));
        check("rst_fill_cnt",   256'(fill_cnt),       256'(0));
        check("rst_wb_cnt",     256'(wb_cnt),         256'(0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Backpressure: response must hold while resp_ready is low.
        bus.resp_ready = 1'b0;
        drive_req(1'b0, 32'd5, 32'd0, 256'h0);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.resp_valid) begin
                    seen = 1;
                    break;
                end
            end
            check("bp_resp_seen", 256'(seen), 256'(1));
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("bp_valid_c%0d", i), 256'(bus.resp_valid), 256'(1));
            check($sformatf("bp_data_c%0d", i),  bus.resp_data,        256'hA5);
            check($sformatf("bp_ready_c%0d", i), 256'(bus.req_ready),  256'(0));
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 256'(bus.resp_valid), 256'(0));
        check("bp_release_ready", 256'(bus.req_ready),  256'(1));

        // Asynchronous reset in the middle of a writeback.
        drive_req(1'b1, 32'd5, 32'd11, 256'hCAFE);
        #2;
        check("mid_wb_wr_en", 256'(bus.mem_wr_en), 256'(1));
        reset = 1'b0;
        #1;
        check("arst_wr_en",      256'(bus.mem_wr_en),  256'(0));
        check("arst_req_ready",  256'(bus.req_ready),  256'(1));
        check("arst_resp_valid", 256'(bus.resp_valid), 256'(0));
        check("arst_mem_addr",   256'(bus.mem_addr),   256'(0));
        check("arst_mem_data",   bus.mem_data,         256'h0);
        check("arst_fill_cnt",   256'(fill_cnt),       256'(0));
        check("arst_wb_cnt",     256'(wb_cnt),         256'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_no_write",     dmem[11],            256'h0);
        check("arst_ready_after",  256'(bus.req_ready), 256'(1));
        run_vec("post_rst", post_rst);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
